uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 139 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Two-requester round-robin arbiter in front of a UART transmitter (start, LSB-first data, stop).
// Define UART_ARB_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx_arbiter #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [1:0]           bd_sel_in,
  output logic [1:0]           bd_rate,
  input  logic                 req0,
  input  logic                 req1,
  input  logic [DATA_BITS-1:0] data0,
  input  logic [DATA_BITS-1:0] data1,
  output logic                 ack0,
  output logic                 ack1,
  output logic                 grant,
  output logic                 busy,
  output logic                 tx,
  output logic [2:0]           state_dbg
);

  localparam int CW = ($clog2(OVERSAMPLE) > 4) ? $clog2(OVERSAMPLE) : 4;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_ARB_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]           state;
  logic [CW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shifted;
`ifdef UART_ARB_PARITY_EN
  logic [DATA_BITS-1:0] data_q;
`endif
  logic                 grant_now;
  logic                 win;
  logic                 bit_done;

  // On a tie the requester that did not own the last frame wins.
  always_comb begin
    grant_now = (state == IDLE) && (req0 || req1);
    win       = (req0 && req1) ? ~grant : req1;
    bit_done  = tick && (tick_cnt == TICK_LAST);
    shifted   = shreg >> 1;
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      tx       <= 1'b1;
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      grant    <= 1'b1;
      bd_rate  <= 2'b00;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
`ifdef UART_ARB_PARITY_EN
      data_q   <= '0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (state == IDLE) begin
        // Ticks arriving on the grant edge are deliberately not counted.
        tick_cnt <= '0;
        bit_idx  <= '0;
        if (grant_now) begin
          state   <= START;
          tx      <= 1'b0;
          grant   <= win;
          bd_rate <= bd_sel_in;
          shreg   <= win ? data1 : data0;
`ifdef UART_ARB_PARITY_EN
          data_q  <= win ? data1 : data0;
`endif
          ack0    <= ~win;
          ack1    <= win;
        end
      end else if (tick) begin
        if (bit_done) begin
          tick_cnt <= '0;
          case (state)
            START: begin
              state   <= DATA;
              tx      <= shreg[0];
              bit_idx <= '0;
            end
            DATA: begin
              if (bit_idx == BIT_LAST) begin
`ifdef UART_ARB_PARITY_EN
                state <= PARITY;
                tx    <= ^data_q;
`else
                state <= STOP;
                tx    <= 1'b1;
`endif
              end else begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= shifted;
                tx      <= shifted[0];
              end
            end
`ifdef UART_ARB_PARITY_EN
            PARITY: begin
              state <= STOP;
              tx    <= 1'b1;
            end
`endif
            STOP: begin
              state <= IDLE;
              tx    <= 1'b1;
            end
            default: begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          endcase
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: expected serial bits are queued on each grant and
// popped at the middle of every bit period; tick is a 1-in-4 clock strobe.
module tb_uart_tx_arbiter;

`ifdef UART_ARB_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] bd_sel_in = 2'b00;
  logic [1:0] bd_rate;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] data0 = 8'h00, data1 = 8'h00;
  logic       ack0, ack1, grant, busy, tx;
  logic [2:0] state_dbg;

  logic [0:0] exp_q[$];
  int asserts = 0;
  int failures = 0;
  int ack0_cnt = 0, ack1_cnt = 0;
  logic tick_en = 1'b1;
  int waited;

  uart_tx_arbiter #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
    .clk(clk), .rst(rst), .tick(tick), .bd_sel_in(bd_sel_in), .bd_rate(bd_rate),
    .req0(req0), .req1(req1), .data0(data0), .data1(data1),
    .ack0(ack0), .ack1(ack1), .grant(grant), .busy(busy), .tx(tx), .state_dbg(state_dbg)
  );

  // clock / tick / ack monitor
  always #5 clk = ~clk;

  initial begin
    int div;
    div = 0;
    forever begin
      @(posedge clk);
      #2;
      tick = tick_en && (div == 3);
      div = (div + 1) % 4;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (ack0 === 1'b1) ack0_cnt++;
      if (ack1 === 1'b1) ack1_cnt++;
    end
  end

  task automatic push_frame(input logic [7:0] d);
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
`ifdef UART_ARB_PARITY_EN
    exp_q.push_back(^d);
`endif
    exp_q.push_back(1'b1);
  endtask

  // Waits for the grant of requester idx, then follows the frame tick by tick.
  task automatic run_frame(input int idx, input logic [7:0] d, input logic [1:0] exp_bd,
                           input logic [1:0] bd_mid, input int stall, input bit keep_req,
                           output int wcyc);
    int cnt, cyc, stall_left;
    bit first, ticked;
    logic [2:0] st0;
    logic [1:0] exp_ack;
    wcyc = 0;
    while (!(ack0 || ack1) && wcyc < 2000) begin
      @(negedge clk);
      wcyc++;
    end
    asserts++;
    if (!(ack0 || ack1)) begin
      failures++;
      $display("FAIL ack_timeout: no ack after %0d cycles, required ack%0d", wcyc, idx);
      return;
    end
    exp_ack = (idx == 1) ? 2'b10 : 2'b01;
    asserts++;
    if ({ack1, ack0} !== exp_ack) begin
      failures++;
      $display("FAIL ack_select: got %b required %b", {ack1, ack0}, exp_ack);
    end
    asserts++;
    if (grant !== idx[0]) begin
      failures++;
      $display("FAIL grant: got %b required %b", grant, idx[0]);
    end
    asserts++;
    if (bd_rate !== exp_bd) begin
      failures++;
      $display("FAIL bd_rate_grant: got %b required %b", bd_rate, exp_bd);
    end
    asserts++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_bit: got tx=%b busy=%b required tx=0 busy=1", tx, busy);
    end
    push_frame(d);
    if (!keep_req) begin
      if (idx == 1) req1 = 1'b0; else req0 = 1'b0;
    end
    cnt = 0;
    cyc = 0;
    stall_left = stall;
    first = 1'b1;
    st0 = state_dbg;
    while (cnt < OS * NB && cyc < 20000) begin
      @(posedge clk);
      ticked = tick;
      if (ticked) cnt++;
      @(negedge clk);
      cyc++;
      if (first) begin
        first = 1'b0;
        asserts++;
        if (ack0 !== 1'b0 || ack1 !== 1'b0) begin
          failures++;
          $display("FAIL ack_pulse: got ack1=%b ack0=%b one cycle later, required 0", ack1, ack0);
        end
      end
      if (stall_left > 0) begin
        tick_en = 1'b0;
        asserts++;
        if (tx !== 1'b0 || state_dbg !== st0 || cnt >= OS) begin
          failures++;
          $display("FAIL tick_stall: got tx=%b state=%0d required tx=0 state=%0d", tx, state_dbg, st0);
        end
        stall_left--;
        if (stall_left == 0) tick_en = 1'b1;
      end
      if (ticked && cnt == 40) bd_sel_in = bd_mid;
      if (ticked && (cnt % OS) == OS / 2) begin
        asserts++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL scoreboard_empty: bit %0d sampled tx=%b with no expectation", cnt / OS, tx);
        end else if (tx !== exp_q[0]) begin
          failures++;
          $display("FAIL tx_bit%0d: got %b required %b", cnt / OS, tx, exp_q[0]);
          void'(exp_q.pop_front());
        end else begin
          void'(exp_q.pop_front());
        end
      end
    end
    asserts++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL frame_timeout: only %0d of %0d ticks seen", cnt, OS * NB);
    end
    asserts++;
    if (busy !== 1'b0 || tx !== 1'b1 || bd_rate !== exp_bd) begin
      failures++;
      $display("FAIL frame_end: got busy=%b tx=%b bd_rate=%b required busy=0 tx=1 bd_rate=%b",
               busy, tx, bd_rate, exp_bd);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #2 rst = 1'b1;
    #1;
    asserts++;
    if (tx !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0 ||
        grant !== 1'b1 || bd_rate !== 2'b00) begin
      failures++;
      $display("FAIL reset_values: got tx=%b busy=%b ack=%b%b grant=%b bd=%b required 1 0 00 1 00",
               tx, busy, ack1, ack0, grant, bd_rate);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    asserts++;
    if (busy !== 1'b0 || ack0_cnt != 0 || ack1_cnt != 0) begin
      failures++;
      $display("FAIL idle_after_reset: got busy=%b acks=%0d/%0d required 0 0/0", busy, ack0_cnt, ack1_cnt);
    end
  endtask

  task automatic test_tie;
    int a0, a1;
    a0 = ack0_cnt;
    a1 = ack1_cnt;
    data0 = 8'h11;
    data1 = 8'h22;
    bd_sel_in = 2'b01;
    req0 = 1'b1;
    req1 = 1'b1;
    run_frame(0, 8'h11, 2'b01, 2'b01, 0, 1'b0, waited);
    run_frame(1, 8'h22, 2'b01, 2'b01, 0, 1'b0, waited);
    asserts++;
    if (waited != 1) begin
      failures++;
      $display("FAIL tie_gap: got %0d idle cycles required 1", waited);
    end
    asserts++;
    if (ack0_cnt - a0 != 1 || ack1_cnt - a1 != 1) begin
      failures++;
      $display("FAIL tie_ack_count: got %0d/%0d required 1/1", ack0_cnt - a0, ack1_cnt - a1);
    end
  endtask

  task automatic test_single;
    data0 = 8'hA5;
    bd_sel_in = 2'b01;
    @(negedge clk);
    req0 = 1'b1;
    run_frame(0, 8'hA5, 2'b01, 2'b01, 0, 1'b0, waited);
  endtask

  task automatic test_bd_change;
    data1 = 8'h3C;
    bd_sel_in = 2'b01;
    @(negedge clk);
    req1 = 1'b1;
    run_frame(1, 8'h3C, 2'b01, 2'b11, 0, 1'b0, waited);
    data0 = 8'h07;
    req0 = 1'b1;
    run_frame(0, 8'h07, 2'b11, 2'b11, 0, 1'b0, waited);
  endtask

  task automatic test_tick_stall;
    data0 = 8'h5A;
    bd_sel_in = 2'b10;
    @(negedge clk);
    req0 = 1'b1;
    run_frame(0, 8'h5A, 2'b10, 2'b10, 100, 1'b0, waited);
  endtask

  task automatic test_back_to_back;
    int a0;
    logic [7:0] d;
    d = 8'($urandom_range(0, 255));
    data0 = d;
    bd_sel_in = 2'b00;
    a0 = ack0_cnt;
    @(negedge clk);
    req0 = 1'b1;
    run_frame(0, d, 2'b00, 2'b00, 0, 1'b1, waited);
    asserts++;
    if (ack0_cnt - a0 != 1) begin
      failures++;
      $display("FAIL held_req_regrant: got %0d acks during frame required 1", ack0_cnt - a0);
    end
    d = 8'($urandom_range(0, 255));
    data0 = d;
    run_frame(0, d, 2'b00, 2'b00, 0, 1'b0, waited);
    asserts++;
    if (waited != 1) begin
      failures++;
      $display("FAIL back_to_back_gap: got %0d idle cycles required 1", waited);
    end
  endtask

  task automatic test_reset_mid_frame;
    int cnt, cyc, a0;
    data0 = 8'hF0;
    bd_sel_in = 2'b01;
    @(negedge clk);
    req0 = 1'b1;
    cyc = 0;
    while (!ack0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    cnt = 0;
    while (cnt < OS * 4 + OS / 2 && cyc < 4000) begin
      @(posedge clk);
      if (tick) cnt++;
      @(negedge clk);
      cyc++;
    end
    asserts++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL data_bit3: got tx=%b busy=%b required tx=0 busy=1", tx, busy);
    end
    a0 = ack0_cnt;
    #2 rst = 1'b1;
    #1;
    asserts++;
    if (tx !== 1'b1 || busy !== 1'b0 || ack0 !== 1'b0 || grant !== 1'b1 || bd_rate !== 2'b00) begin
      failures++;
      $display("FAIL async_abort: got tx=%b busy=%b ack0=%b grant=%b bd=%b required 1 0 0 1 00",
               tx, busy, ack0, grant, bd_rate);
    end
    repeat (3) @(negedge clk);
    asserts++;
    if (ack0_cnt != a0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_ack: got %0d extra acks busy=%b required 0 0", ack0_cnt - a0, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    asserts++;
    if (ack0 !== 1'b1) begin
      failures++;
      $display("FAIL regrant_first_edge: got ack0=%b required 1", ack0);
    end
    run_frame(0, 8'hF0, 2'b01, 2'b01, 0, 1'b0, waited);
  endtask

  initial begin
    test_reset();
    test_tie();
    test_single();
    test_bd_change();
    test_tick_stall();
    test_back_to_back();
    test_reset_mid_frame();
    repeat (4) @(negedge clk);
    asserts++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover: got %0d unchecked bits required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
